// File: rtl/des_key_schedule_if.sv
// Start/done control plus the per-round C/D stream of the DES key schedule.
// The decrypt select exists only when KEYSCHED_DECRYPT_EN is defined.
interface des_key_schedule_if;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [63:0] key;
  logic [27:0] round_C;
  logic [27:0] round_D;
  logic [3:0]  round_idx;
  logic        round_vld;
  logic        round_rdy;
`ifdef KEYSCHED_DECRYPT_EN
  logic        decrypt;

  modport master (
    output ap_start, key, round_rdy, decrypt,
    input  ap_done, ap_idle, ap_ready, round_C, round_D, round_idx, round_vld
  );
  modport slave (
    input  ap_start, key, round_rdy, decrypt,
    output ap_done, ap_idle, ap_ready, round_C, round_D, round_idx, round_vld
  );
`else
  modport master (
    output ap_start, key, round_rdy,
    input  ap_done, ap_idle, ap_ready, round_C, round_D, round_idx, round_vld
  );
  modport slave (
    input  ap_start, key, round_rdy,
    output ap_done, ap_idle, ap_ready, round_C, round_D, round_idx, round_vld
  );
`endif
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 latched on ap_start, C/D of rounds 1..16 streamed out; KEYSCHED_DECRYPT_EN adds K16..K1 order.
// Latency: first round_vld 2 cycles after the ap_start cycle, ap_done 18 cycles after it when never stalled.
// Backpressure: each round holds on round_C/round_D/round_idx until round_vld & round_rdy.
module des_key_schedule (
  input  logic              ap_clk,
  input  logic              ap_rst,
  des_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  // PC-1 in DES bit numbering (bit 1 = key[63]); first 28 entries form C, the rest D.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_t      state, state_nxt;
  logic        load_key, first_round, advance;
  logic [55:0] pc1_cd;
  logic [27:0] c_q, d_q;
  logic [3:0]  idx_q;
  logic [4:0]  next_round;
  logic        two_step;

`ifdef KEYSCHED_DECRYPT_EN
  logic dec_q;
`else
  localparam logic dec_q = 1'b0;
`endif

  always_comb begin
    pc1_cd = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_cd[55-i] = bus.key[64-PC1[i]];
    end
  end

  // Rounds 2, 9 and 16 move by one position in either direction, all others by two.
  assign next_round = {1'b0, idx_q} + 5'd2;
  assign two_step   = !((next_round == 5'd2) || (next_round == 5'd9) || (next_round == 5'd16));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    load_key      = 1'b0;
    first_round   = 1'b0;
    advance       = 1'b0;
    bus.ap_idle   = 1'b0;
    bus.ap_done   = 1'b0;
    bus.ap_ready  = 1'b0;
    bus.round_vld = 1'b0;
    case (state)
      IDLE: begin
        bus.ap_idle = 1'b1;
        if (bus.ap_start) begin
          load_key  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        first_round = 1'b1;
        state_nxt   = EMIT;
      end
      EMIT: begin
        bus.round_vld = 1'b1;
        if (bus.round_rdy) begin
          if (idx_q == 4'd15) begin
            state_nxt = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE: begin
        bus.ap_done  = 1'b1;
        bus.ap_ready = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      c_q   <= '0;
      d_q   <= '0;
      idx_q <= '0;
`ifdef KEYSCHED_DECRYPT_EN
      dec_q <= 1'b0;
`endif
    end else if (load_key) begin
      c_q <= pc1_cd[55:28];
      d_q <= pc1_cd[27:0];
`ifdef KEYSCHED_DECRYPT_EN
      dec_q <= bus.decrypt;
`endif
    end else if (first_round) begin
      // Decrypt starts from C16/D16, which equals the unrotated C0/D0.
      idx_q <= '0;
      if (!dec_q) begin
        c_q <= rotl(c_q, 1'b0);
        d_q <= rotl(d_q, 1'b0);
      end
    end else if (advance) begin
      idx_q <= idx_q + 4'd1;
      if (dec_q) begin
        c_q <= rotr(c_q, two_step);
        d_q <= rotr(d_q, two_step);
      end else begin
        c_q <= rotl(c_q, two_step);
        d_q <= rotl(d_q, two_step);
      end
    end
  end

  assign bus.round_C   = c_q;
  assign bus.round_D   = d_q;
  assign bus.round_idx = idx_q;

endmodule
